// File: rtl/press_emulator.sv
// Turns single-cycle request pulses into active-low button presses (hold, then released gap),
// queueing overlapping requests. Optional bounce prefix enabled by defining PRESS_BOUNCE_EN.
module press_emulator #(
  parameter int unsigned HOLD_CYCLES   = 4,
  parameter int unsigned GAP_CYCLES    = 2,
  parameter int unsigned CNT_W         = 8,
  parameter int unsigned PEND_W        = 2,
  parameter int unsigned BOUNCE_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p_in,
  output logic              lvl_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              ovf
);

  if (HOLD_CYCLES < 1 || HOLD_CYCLES >= (1 << CNT_W)) begin : g_bad_hold
    $error("press_emulator: HOLD_CYCLES out of range");
  end
  if (GAP_CYCLES < 1 || GAP_CYCLES >= (1 << CNT_W)) begin : g_bad_gap
    $error("press_emulator: GAP_CYCLES out of range");
  end
  if (BOUNCE_CYCLES >= (1 << CNT_W)) begin : g_bad_bounce
    $error("press_emulator: BOUNCE_CYCLES out of range");
  end

`ifdef PRESS_BOUNCE_EN
  typedef enum logic [1:0] {IDLE, HOLD, GAP, BOUNCE} state_t;
  localparam state_t START = BOUNCE;
  localparam logic [CNT_W-1:0] BOUNCE_LAST = CNT_W'(BOUNCE_CYCLES - 1);
`else
  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;
  localparam state_t START = HOLD;
`endif

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  state_t            state, state_n;
  logic [CNT_W-1:0]  timer, timer_n;
  logic [PEND_W-1:0] pending_n;
  logic              ovf_n, lvl_n, busy_n;
  logic              deq, req_q;

  always_comb begin
    state_n   = state;
    timer_n   = timer + CNT_W'(1);
    deq       = 1'b0;
    req_q     = p_in && (state != IDLE);
    pending_n = pending;
    ovf_n     = 1'b0;

    case (state)
      IDLE: begin
        timer_n = '0;
        if (p_in) state_n = START;
      end
`ifdef PRESS_BOUNCE_EN
      BOUNCE: begin
        if (timer == BOUNCE_LAST) begin
          state_n = HOLD;
          timer_n = '0;
        end
      end
`endif
      HOLD: begin
        if (timer == HOLD_LAST) begin
          state_n = GAP;
          timer_n = '0;
        end
      end
      GAP: begin
        if (timer == GAP_LAST) begin
          timer_n = '0;
          // A request on this edge can itself be dequeued, so a same-edge request counts as pending.
          if (pending != '0 || p_in) begin
            state_n = START;
            deq     = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: begin
        state_n = IDLE;
        timer_n = '0;
      end
    endcase

    if (deq && !req_q) begin
      pending_n = pending - PEND_W'(1);
    end else if (!deq && req_q) begin
      if (&pending) ovf_n = 1'b1;
      else          pending_n = pending + PEND_W'(1);
    end

    // Outputs are registered from next-state values so p_in never reaches them combinationally.
    lvl_n = 1'b1;
    if (state_n == HOLD) lvl_n = 1'b0;
`ifdef PRESS_BOUNCE_EN
    if (state_n == BOUNCE) lvl_n = timer_n[0];
`endif
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      timer   <= '0;
      pending <= '0;
      ovf     <= 1'b0;
      lvl_out <= 1'b1;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      timer   <= timer_n;
      pending <= pending_n;
      ovf     <= ovf_n;
      lvl_out <= lvl_n;
      busy    <= busy_n;
    end
  end

endmodule

// File: doc/press_emulator.md
# press_emulator

Generates active-low, button-style press levels from single-cycle request pulses, the inverse of the button shaping path. Each accepted request becomes one held-low press of fixed length followed by a mandatory released gap, so a downstream shaper sees exactly one clean press per request. Used for self-test and demo playback in the mental-math game, where it drives the button input of the shaping logic in place of a physical button. Requests that arrive while a press is in progress are queued in a saturating pending counter.

## Interface
- HOLD_CYCLES, 4: cycles lvl_out is held low per press; must be ≥1.
- GAP_CYCLES, 2: cycles lvl_out is held high after each press; must be ≥1.
- CNT_W, 8: width of the hold/gap timer; HOLD_CYCLES and GAP_CYCLES must each be < 2^CNT_W.
- PEND_W, 2: width of the pending-request counter; it saturates at 2^PEND_W−1.
- BOUNCE_CYCLES, 3: length of the bounce prefix; used only with PRESS_BOUNCE_EN.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- p_in  in  1  press request, sampled at every rising edge; a level held high counts as one request per cycle.
- lvl_out  out  1  emulated button level: 1 = released, 0 = pressed; registered.
- busy  out  1  high while in HOLD or GAP.
- pending  out  PEND_W  number of queued requests not yet started.
- ovf  out  1  one-cycle pulse: a request was dropped because pending was saturated.

## Operation
- States: IDLE, HOLD, GAP (plus BOUNCE when PRESS_BOUNCE_EN is defined). Timer counts cycles within HOLD, GAP and BOUNCE.
- Reset values (rst = 0 at an edge): state IDLE, lvl_out = 1, busy = 0, pending = 0, ovf = 0, timer = 0. Reset mid-press aborts the press and clears the queue; lvl_out is 1 on the following cycle.
- IDLE:
  - p_in = 1 → HOLD; timer loads; pending is unchanged (0).
- HOLD:
  - lvl_out = 0 for exactly HOLD_CYCLES cycles, then → GAP.
- GAP:
  - lvl_out = 1 for exactly GAP_CYCLES cycles.
  - On the last GAP cycle: if pending > 0, → HOLD and pending decrements; otherwise → IDLE.
- A request arriving in HOLD, GAP or BOUNCE increments pending.
- If pending is saturated, the request is dropped, pending holds, and ovf = 1 next cycle.
- Simultaneous request and dequeue on the same edge: pending is unchanged, and ovf is never raised for that case.
- A request on the last GAP cycle while pending = 0 is queued (pending = 1) and immediately dequeued: net → HOLD, pending stays 0.
- busy = (state ≠ IDLE).

## Timing
- Request latency: p_in high in cycle n (IDLE) → lvl_out = 0 in cycles n+1 … n+HOLD_CYCLES.
- lvl_out = 1 in cycles n+HOLD_CYCLES+1 … n+HOLD_CYCLES+GAP_CYCLES.
- busy is high over cycles n+1 … n+HOLD_CYCLES+GAP_CYCLES.
- Back-to-back presses have a period of HOLD_CYCLES+GAP_CYCLES; there is no idle cycle between a GAP and the next HOLD.
- All outputs are registered; there is no combinational path from p_in to any output.

## Configuration
- PRESS_BOUNCE_EN defined:
  - Each press begins with a BOUNCE phase of BOUNCE_CYCLES cycles in which lvl_out alternates, starting with 0 (0,1,0,…).
  - BOUNCE is followed by the normal HOLD of HOLD_CYCLES.
  - Press period becomes BOUNCE_CYCLES+HOLD_CYCLES+GAP_CYCLES.
  - Used to stress debounce and shaping logic.
- PRESS_BOUNCE_EN not defined:
  - No BOUNCE state exists; a press is a clean low of HOLD_CYCLES.
  - BOUNCE_CYCLES is ignored.

## Test plan
All scenarios use defaults (HOLD=4, GAP=2, PEND_W=2) unless stated.
- Reset: hold rst = 0 for 3 cycles with p_in toggling → lvl_out = 1, busy = 0, pending = 0, ovf = 0 throughout.
- Single request: p_in pulse at cycle 10 → lvl_out = 0 in cycles 11–14 and 1 in cycles 15–16; busy high in 11–16; IDLE at 17.
- Queueing: pulses at cycles 10, 11, 12 → pending reads 1 then 2; three low windows at 11–14, 17–20, 23–26; pending = 0 after cycle 22.
- Overflow: pulses every cycle from 10 to 14 → pending saturates at 3 by cycle 14; ovf = 1 for cycle 15 only; exactly 4 presses emitted.
- Reset mid-press: rst = 0 at cycle 12 with pending = 2 → lvl_out = 1 and pending = 0 from cycle 13; no further presses.
- Loopback into the team's button shaper block, with and without PRESS_BOUNCE_EN (BOUNCE=3):
  - Macro not defined: 5 requests → exactly 5 shaper pulses.
  - Macro defined: each press shows lvl_out pattern 0,1,0 before 4 steady low cycles; the shaper pulse count is recorded.
